// File: rtl/layer1_pool_pkg.sv
// Shared widths, frame defaults and helpers for the layer-1 2x2 max-pool stage.
// Pure declarations: no latency, no flow control.
package layer1_pool_pkg;

    localparam int DATA_W   = 16;
    localparam int CH_NUM   = 16;
    localparam int CNT_W    = 7;
    localparam int IN_W_DEF = 24;
    localparam int IN_H_DEF = 24;

    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Per-pixel strobes shared by every channel lane.
    typedef struct packed {
        logic left_we;
        logic lb_we;
        logic out_we;
    } lane_ctl_t;

    function automatic pix_t umax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the 2x2 max-pool: left register, line-buffer slice, comparators, output register.
// Output 1 cycle after the odd/odd pixel; no backpressure, strobes come from the control in the top.
module pool_lane
    import layer1_pool_pkg::*;
#(
    parameter int LB_D  = IN_W_DEF / 2,
    parameter int IDX_W = idx_width(LB_D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  lane_ctl_t        i_ctl,
    input  logic [IDX_W-1:0] i_idx,
    input  pix_t             i_data,
    output pix_t             o_data
);

    pix_t r_left;
    pix_t r_lb [LB_D];
    pix_t r_out;
    pix_t w_hmax;
    pix_t w_lb_rd;

    assign w_hmax  = umax(r_left, i_data);
    assign w_lb_rd = r_lb[i_idx];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_left <= '0;
        end else if (i_ctl.left_we) begin
            r_left <= i_data;
        end
    end

    // Line buffer is deliberately unreset so it can map onto RAM; even rows overwrite it.
    always_ff @(posedge clk) begin
        if (i_ctl.lb_we) begin
            r_lb[i_idx] <= w_hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (i_ctl.out_we) begin
            r_out <= umax(w_lb_rd, w_hmax);
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/layer1_maxpool.sv
// 2x2 stride-2 max-pool over 16 ReLU channels; result registered 1 cycle after the odd/odd pixel, href-paced, no backpressure.
// Optional sticky column-sequence checker (pool_err) is built only with LAYER1_MAXPOOL_ERR_EN defined.
module layer1_maxpool
    import layer1_pool_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int IN_H = IN_H_DEF
) (
`ifdef LAYER1_MAXPOOL_ERR_EN
    output logic             pool_err,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             relu_vsync,
    input  logic             relu_href,
    input  logic [CNT_W-1:0] relu_h_cnt,
    input  logic [CNT_W-1:0] relu_v_cnt,
    input  logic [DATA_W-1:0] relu_data1,
    input  logic [DATA_W-1:0] relu_data2,
    input  logic [DATA_W-1:0] relu_data3,
    input  logic [DATA_W-1:0] relu_data4,
    input  logic [DATA_W-1:0] relu_data5,
    input  logic [DATA_W-1:0] relu_data6,
    input  logic [DATA_W-1:0] relu_data7,
    input  logic [DATA_W-1:0] relu_data8,
    input  logic [DATA_W-1:0] relu_data9,
    input  logic [DATA_W-1:0] relu_data10,
    input  logic [DATA_W-1:0] relu_data11,
    input  logic [DATA_W-1:0] relu_data12,
    input  logic [DATA_W-1:0] relu_data13,
    input  logic [DATA_W-1:0] relu_data14,
    input  logic [DATA_W-1:0] relu_data15,
    input  logic [DATA_W-1:0] relu_data16,
    output logic             pool_vsync,
    output logic             pool_href,
    output logic [CNT_W-1:0] pool_h_cnt,
    output logic [CNT_W-1:0] pool_v_cnt,
    output logic [DATA_W-1:0] pool_data1,
    output logic [DATA_W-1:0] pool_data2,
    output logic [DATA_W-1:0] pool_data3,
    output logic [DATA_W-1:0] pool_data4,
    output logic [DATA_W-1:0] pool_data5,
    output logic [DATA_W-1:0] pool_data6,
    output logic [DATA_W-1:0] pool_data7,
    output logic [DATA_W-1:0] pool_data8,
    output logic [DATA_W-1:0] pool_data9,
    output logic [DATA_W-1:0] pool_data10,
    output logic [DATA_W-1:0] pool_data11,
    output logic [DATA_W-1:0] pool_data12,
    output logic [DATA_W-1:0] pool_data13,
    output logic [DATA_W-1:0] pool_data14,
    output logic [DATA_W-1:0] pool_data15,
    output logic [DATA_W-1:0] pool_data16
);

    localparam int   LB_D  = IN_W / 2;
    localparam int   IDX_W = idx_width(LB_D);
    localparam cnt_t H_LIM = cnt_t'(2 * (IN_W / 2));
    localparam cnt_t V_LIM = cnt_t'(2 * (IN_H / 2));

    logic             r_vsync_d;
    logic             r_armed;
    logic             r_href;
    cnt_t             r_h;
    cnt_t             r_v;
    logic             w_vs_rise;
    logic             w_acc;
    lane_ctl_t        w_ctl;
    logic [IDX_W-1:0] w_idx;
    pix_t             w_din  [CH_NUM];
    pix_t             w_dout [CH_NUM];

    assign w_vs_rise = relu_vsync & ~r_vsync_d;
    // r_armed blocks a frame interrupted by reset from producing output until the next vsync.
    assign w_acc = r_armed & relu_href & (relu_h_cnt < H_LIM) & (relu_v_cnt < V_LIM);
    assign w_idx = IDX_W'(relu_h_cnt >> 1);

    always_comb begin
        w_ctl         = '0;
        w_ctl.left_we = w_acc & ~relu_h_cnt[0];
        w_ctl.lb_we   = w_acc &  relu_h_cnt[0] & ~relu_v_cnt[0];
        w_ctl.out_we  = w_acc &  relu_h_cnt[0] &  relu_v_cnt[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_armed   <= 1'b0;
            r_href    <= 1'b0;
            r_h       <= '0;
            r_v       <= '0;
        end else begin
            r_vsync_d <= relu_vsync;
            if (w_vs_rise) begin
                r_armed <= 1'b1;
            end
            r_href <= w_ctl.out_we;
            if (w_ctl.out_we) begin
                r_h <= relu_h_cnt >> 1;
                r_v <= relu_v_cnt >> 1;
            end
        end
    end

    assign pool_vsync = r_vsync_d;
    assign pool_href  = r_href;
    assign pool_h_cnt = r_h;
    assign pool_v_cnt = r_v;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
        pool_lane #(
            .LB_D  (LB_D),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_clr  (w_vs_rise),
            .i_ctl  (w_ctl),
            .i_idx  (w_idx),
            .i_data (w_din[g]),
            .o_data (w_dout[g])
        );
    end

    assign w_din[0]  = relu_data1;
    assign w_din[1]  = relu_data2;
    assign w_din[2]  = relu_data3;
    assign w_din[3]  = relu_data4;
    assign w_din[4]  = relu_data5;
    assign w_din[5]  = relu_data6;
    assign w_din[6]  = relu_data7;
    assign w_din[7]  = relu_data8;
    assign w_din[8]  = relu_data9;
    assign w_din[9]  = relu_data10;
    assign w_din[10] = relu_data11;
    assign w_din[11] = relu_data12;
    assign w_din[12] = relu_data13;
    assign w_din[13] = relu_data14;
    assign w_din[14] = relu_data15;
    assign w_din[15] = relu_data16;

    assign pool_data1  = w_dout[0];
    assign pool_data2  = w_dout[1];
    assign pool_data3  = w_dout[2];
    assign pool_data4  = w_dout[3];
    assign pool_data5  = w_dout[4];
    assign pool_data6  = w_dout[5];
    assign pool_data7  = w_dout[6];
    assign pool_data8  = w_dout[7];
    assign pool_data9  = w_dout[8];
    assign pool_data10 = w_dout[9];
    assign pool_data11 = w_dout[10];
    assign pool_data12 = w_dout[11];
    assign pool_data13 = w_dout[12];
    assign pool_data14 = w_dout[13];
    assign pool_data15 = w_dout[14];
    assign pool_data16 = w_dout[15];

`ifdef LAYER1_MAXPOOL_ERR_EN
    cnt_t r_prev_h;
    cnt_t r_prev_v;
    logic r_line_vld;
    logic r_err;
    logic w_bad;

    // A new line is recognised by a change of v_cnt; its first pixel must be column 0.
    always_comb begin
        w_bad = 1'b0;
        if (w_acc) begin
            if (!r_line_vld || (relu_v_cnt != r_prev_v)) begin
                w_bad = (relu_h_cnt != '0);
            end else begin
                w_bad = (relu_h_cnt != (r_prev_h + cnt_t'(1)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_vs_rise) begin
            r_prev_h   <= '0;
            r_prev_v   <= '0;
            r_line_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_prev_h   <= relu_h_cnt;
                r_prev_v   <= relu_v_cnt;
                r_line_vld <= 1'b1;
            end
            r_err <= r_err | w_bad;
        end
    end

    assign pool_err = r_err;
`endif

endmodule

// File: tb/tb_layer1_maxpool.sv
// Bench for layer1_maxpool: a 24x24 and a 25x25 instance share one stimulus stream.
// Expected outputs are computed from a stored image of each frame with plain 2x2 maxima.
module tb_layer1_maxpool;

    typedef struct packed {
        logic [6:0]        h;
        logic [6:0]        v;
        logic [15:0][15:0] d;
    } out_t;

    typedef struct {
        bit vs; bit hr; int h; int v; int d;
        bit e_vs; bit e_hr; int e_h; int e_v; int e_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        relu_vsync;
    logic        relu_href;
    logic [6:0]  relu_h_cnt;
    logic [6:0]  relu_v_cnt;
    logic [15:0] rd [16];

    logic        pa_vsync, pa_href, pb_vsync, pb_href;
    logic [6:0]  pa_h, pa_v, pb_h, pb_v;
    logic [15:0] pa [16];
    logic [15:0] pb [16];
`ifdef LAYER1_MAXPOOL_ERR_EN
    logic        pa_err, pb_err;
`endif

    int   tests = 0;
    int   fails = 0;
    int   hold_err_a = 0;
    int   hold_err_b = 0;
    logic [15:0] img [25][25][16];
    out_t got_a[$];
    out_t got_b[$];
    out_t exp_q[$];
    out_t last_a, last_b;
    bit   prev_rst = 1'b1;
    vec_t tbl [15];

    always #5 clk = ~clk;

    layer1_maxpool #(.IN_W(24), .IN_H(24)) u_dut_a (
`ifdef LAYER1_MAXPOOL_ERR_EN
        .pool_err(pa_err),
`endif
        .clk(clk), .rst(rst), .relu_vsync(relu_vsync), .relu_href(relu_href),
        .relu_h_cnt(relu_h_cnt), .relu_v_cnt(relu_v_cnt),
        .relu_data1(rd[0]), .relu_data2(rd[1]), .relu_data3(rd[2]), .relu_data4(rd[3]),
        .relu_data5(rd[4]), .relu_data6(rd[5]), .relu_data7(rd[6]), .relu_data8(rd[7]),
        .relu_data9(rd[8]), .relu_data10(rd[9]), .relu_data11(rd[10]), .relu_data12(rd[11]),
        .relu_data13(rd[12]), .relu_data14(rd[13]), .relu_data15(rd[14]), .relu_data16(rd[15]),
        .pool_vsync(pa_vsync), .pool_href(pa_href), .pool_h_cnt(pa_h), .pool_v_cnt(pa_v),
        .pool_data1(pa[0]), .pool_data2(pa[1]), .pool_data3(pa[2]), .pool_data4(pa[3]),
        .pool_data5(pa[4]), .pool_data6(pa[5]), .pool_data7(pa[6]), .pool_data8(pa[7]),
        .pool_data9(pa[8]), .pool_data10(pa[9]), .pool_data11(pa[10]), .pool_data12(pa[11]),
        .pool_data13(pa[12]), .pool_data14(pa[13]), .pool_data15(pa[14]), .pool_data16(pa[15])
    );

    layer1_maxpool #(.IN_W(25), .IN_H(25)) u_dut_b (
`ifdef LAYER1_MAXPOOL_ERR_EN
        .pool_err(pb_err),
`endif
        .clk(clk), .rst(rst), .relu_vsync(relu_vsync), .relu_href(relu_href),
        .relu_h_cnt(relu_h_cnt), .relu_v_cnt(relu_v_cnt),
        .relu_data1(rd[0]), .relu_data2(rd[1]), .relu_data3(rd[2]), .relu_data4(rd[3]),
        .relu_data5(rd[4]), .relu_data6(rd[5]), .relu_data7(rd[6]), .relu_data8(rd[7]),
        .relu_data9(rd[8]), .relu_data10(rd[9]), .relu_data11(rd[10]), .relu_data12(rd[11]),
        .relu_data13(rd[12]), .relu_data14(rd[13]), .relu_data15(rd[14]), .relu_data16(rd[15]),
        .pool_vsync(pb_vsync), .pool_href(pb_href), .pool_h_cnt(pb_h), .pool_v_cnt(pb_v),
        .pool_data1(pb[0]), .pool_data2(pb[1]), .pool_data3(pb[2]), .pool_data4(pb[3]),
        .pool_data5(pb[4]), .pool_data6(pb[5]), .pool_data7(pb[6]), .pool_data8(pb[7]),
        .pool_data9(pb[8]), .pool_data10(pb[9]), .pool_data11(pb[10]), .pool_data12(pb[11]),
        .pool_data13(pb[12]), .pool_data14(pb[13]), .pool_data15(pb[14]), .pool_data16(pb[15])
    );

    // Capture pooled pixels and watch that outputs hold between pulses.
    always @(negedge clk) begin
        out_t sa, sb;
        sa.h = pa_h; sa.v = pa_v;
        sb.h = pb_h; sb.v = pb_v;
        for (int c = 0; c < 16; c++) begin
            sa.d[c] = pa[c];
            sb.d[c] = pb[c];
        end
        if (pa_href) got_a.push_back(sa);
        else if (!prev_rst && sa != last_a) hold_err_a++;
        if (pb_href) got_b.push_back(sb);
        else if (!prev_rst && sb != last_b) hold_err_b++;
        last_a   = sa;
        last_b   = sb;
        prev_rst = rst;
    end

    task automatic chk(input string name, input bit ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        relu_href = 1'b0;
        for (int i = 0; i < n; i++) begin
            relu_h_cnt = 7'($urandom_range(0, 30));
            relu_v_cnt = 7'($urandom_range(0, 30));
            for (int c = 0; c < 16; c++) rd[c] = 16'($urandom);
            tick();
        end
    endtask

    task automatic check_zero(input string name);
        bit za, zb;
        za = !pa_vsync && !pa_href && pa_h == 0 && pa_v == 0;
        zb = !pb_vsync && !pb_href && pb_h == 0 && pb_v == 0;
        for (int c = 0; c < 16; c++) begin
            if (pa[c] != 0) za = 1'b0;
            if (pb[c] != 0) zb = 1'b0;
        end
        chk({name, " A"}, za, $sformatf("got vs%0d hr%0d h%0d v%0d d1=%0d, want all 0",
            pa_vsync, pa_href, pa_h, pa_v, pa[0]));
        chk({name, " B"}, zb, $sformatf("got vs%0d hr%0d h%0d v%0d d1=%0d, want all 0",
            pb_vsync, pb_href, pb_h, pb_v, pb[0]));
    endtask

    task automatic drive_frame(input int w, input int h, input int mode, input int gap_pct,
                               input int skip_v, input int skip_h, input int rst_v, input int rst_h);
        relu_vsync = 1'b1;
        idle(3);
        relu_vsync = 1'b0;
        idle(2);
        for (int v = 0; v < h; v++) begin
            for (int hh = 0; hh < w; hh++) begin
                if (v == skip_v && hh == skip_h) continue;
                while ($urandom_range(99) < gap_pct) idle(1);
                relu_href  = 1'b1;
                relu_h_cnt = 7'(hh);
                relu_v_cnt = 7'(v);
                for (int c = 0; c < 16; c++) begin
                    rd[c] = (mode == 0) ? 16'(v * 24 + hh) : 16'($urandom);
                    img[v][hh][c] = rd[c];
                end
                tick();
                if (v == rst_v && hh == rst_h) begin
                    relu_href = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check_zero("reset mid-frame");
                    got_a.delete();
                    got_b.delete();
                end
            end
            idle(2);
        end
        idle(4);
    endtask

    task automatic build_exp(input int w, input int h);
        out_t e;
        exp_q.delete();
        for (int pv = 0; pv < h / 2; pv++) begin
            for (int ph = 0; ph < w / 2; ph++) begin
                e.h = 7'(ph);
                e.v = 7'(pv);
                for (int c = 0; c < 16; c++) begin
                    logic [15:0] m;
                    m = img[2*pv][2*ph][c];
                    if (img[2*pv][2*ph+1][c]   > m) m = img[2*pv][2*ph+1][c];
                    if (img[2*pv+1][2*ph][c]   > m) m = img[2*pv+1][2*ph][c];
                    if (img[2*pv+1][2*ph+1][c] > m) m = img[2*pv+1][2*ph+1][c];
                    e.d[c] = m;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cmp_q(input string name, input out_t q[$]);
        int bad = 0;
        int first = -1;
        chk({name, " count"}, q.size() == exp_q.size(),
            $sformatf("got %0d pulses, want %0d", q.size(), exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= q.size() || q[i] != exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        chk({name, " data"}, bad == 0, $sformatf(
            "%0d entries differ, first #%0d got h%0d v%0d d1=%0d want h%0d v%0d d1=%0d", bad, first,
            (first < q.size()) ? q[first].h : 0, (first < q.size()) ? q[first].v : 0,
            (first < q.size()) ? q[first].d[0] : 0, exp_q[first].h, exp_q[first].v, exp_q[first].d[0]));
    endtask

    task automatic compare_frame(input string name, input int w, input int h, input bit ramp);
        build_exp(w, h);
        cmp_q({name, " A"}, got_a);
        cmp_q({name, " B"}, got_b);
        if (ramp) begin
            int bad = 0;
            for (int i = 0; i < got_a.size(); i++) begin
                int pv = i / 12;
                int ph = i % 12;
                if (int'(got_a[i].d[0]) != (2*pv+1)*24 + 2*ph + 1 || int'(got_a[i].d[15]) != (2*pv+1)*24 + 2*ph + 1)
                    bad++;
            end
            chk({name, " ramp formula"}, bad == 0 && got_a.size() == 144,
                $sformatf("%0d values off (of %0d), want 0 of 144", bad, got_a.size()));
        end
        got_a.delete();
        got_b.delete();
    endtask

    function automatic vec_t mk(bit vs, bit hr, int h, int v, int d, bit e_vs, bit e_hr, int e_h, int e_v, int e_d);
        vec_t t;
        t.vs = vs; t.hr = hr; t.h = h; t.v = v; t.d = d;
        t.e_vs = e_vs; t.e_hr = e_hr; t.e_h = e_h; t.e_v = e_v; t.e_d = e_d;
        return t;
    endfunction

    initial begin
        tbl[0]  = mk(1, 0, 0,  0, 0,   1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,  0, 0,   0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0,  0, 5,   0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1,  0, 9,   0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 2,  0, 20,  0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 3,  0, 4,   0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 3,  0, 77,  0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0,  1, 3,   0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1,  1, 7,   0, 1, 0, 0, 9);
        tbl[9]  = mk(0, 0, 1,  1, 99,  0, 0, 0, 0, 9);
        tbl[10] = mk(0, 1, 2,  1, 1,   0, 0, 0, 0, 9);
        tbl[11] = mk(0, 0, 2,  1, 0,   0, 0, 0, 0, 9);
        tbl[12] = mk(0, 1, 25, 1, 500, 0, 0, 0, 0, 9);
        tbl[13] = mk(0, 1, 3,  1, 2,   0, 1, 1, 0, 20);
        tbl[14] = mk(0, 0, 0,  0, 0,   0, 0, 1, 0, 20);

        rst = 1'b1;
        relu_vsync = 1'b0;
        relu_href = 1'b0;
        relu_h_cnt = '0;
        relu_v_cnt = '0;
        for (int c = 0; c < 16; c++) rd[c] = '0;
        tick();
        tick();
        check_zero("reset state");
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 15; i++) begin
            bit ok;
            relu_vsync = tbl[i].vs;
            relu_href  = tbl[i].hr;
            relu_h_cnt = 7'(tbl[i].h);
            relu_v_cnt = 7'(tbl[i].v);
            for (int c = 0; c < 16; c++) rd[c] = 16'(tbl[i].d);
            tick();
            ok = pa_vsync == tbl[i].e_vs && pa_href == tbl[i].e_hr && int'(pa_h) == tbl[i].e_h &&
                 int'(pa_v) == tbl[i].e_v && int'(pa[0]) == tbl[i].e_d && int'(pa[15]) == tbl[i].e_d &&
                 pb_vsync == tbl[i].e_vs && pb_href == tbl[i].e_hr && int'(pb_h) == tbl[i].e_h &&
                 int'(pb_v) == tbl[i].e_v && int'(pb[0]) == tbl[i].e_d;
            chk($sformatf("vec%0d", i), ok, $sformatf(
                "got vs%0d hr%0d h%0d v%0d d1=%0d d16=%0d, want vs%0d hr%0d h%0d v%0d d=%0d",
                pa_vsync, pa_href, pa_h, pa_v, pa[0], pa[15],
                tbl[i].e_vs, tbl[i].e_hr, tbl[i].e_h, tbl[i].e_v, tbl[i].e_d));
        end
        idle(3);
        got_a.delete();
        got_b.delete();

        drive_frame(24, 24, 0, 0, -1, -1, -1, -1);
        compare_frame("ramp frame", 24, 24, 1'b1);
`ifdef LAYER1_MAXPOOL_ERR_EN
        chk("err clean ramp", !pa_err && !pb_err, $sformatf("got %0d/%0d, want 0", pa_err, pb_err));
`endif

        drive_frame(24, 24, 1, 30, -1, -1, -1, -1);
        compare_frame("stall frame", 24, 24, 1'b0);

        drive_frame(25, 25, 1, 10, -1, -1, -1, -1);
        compare_frame("odd-size frame", 25, 25, 1'b0);

        drive_frame(24, 24, 1, 0, -1, -1, 7, 10);
        chk("after reset A", got_a.size() == 0, $sformatf("got %0d pulses, want 0", got_a.size()));
        chk("after reset B", got_b.size() == 0, $sformatf("got %0d pulses, want 0", got_b.size()));
        got_a.delete();
        got_b.delete();

        drive_frame(24, 24, 1, 15, -1, -1, -1, -1);
        compare_frame("post-reset frame", 24, 24, 1'b0);

`ifdef LAYER1_MAXPOOL_ERR_EN
        drive_frame(24, 24, 1, 0, 2, 6, -1, -1);
        idle(5);
        chk("err skip set", pa_err && pb_err, $sformatf("got %0d/%0d, want 1", pa_err, pb_err));
        got_a.delete();
        got_b.delete();
        drive_frame(24, 24, 1, 5, -1, -1, -1, -1);
        chk("err clean frame", !pa_err && !pb_err, $sformatf("got %0d/%0d, want 0", pa_err, pb_err));
        compare_frame("frame after err", 24, 24, 1'b0);
`endif

        chk("hold A", hold_err_a == 0, $sformatf("got %0d changes while idle, want 0", hold_err_a));
        chk("hold B", hold_err_b == 0, $sformatf("got %0d changes while idle, want 0", hold_err_b));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer1_maxpool.md
LAYER1_MAXPOOL -- requirements
Module: layer1_maxpool

Interface
REQ-001 SHALL have parameter IN_W, default 24: active columns per input line.
REQ-002 SHALL have parameter IN_H, default 24: active lines per input frame.
REQ-003 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port relu_vsync, input, 1: frame sync from the ReLU stage.
REQ-006 SHALL have port relu_href, input, 1: pixel valid from the ReLU stage.
REQ-007 SHALL have ports relu_h_cnt and relu_v_cnt, input, 7 each: column and row of the current pixel.
REQ-008 SHALL have ports relu_data1..relu_data16, input, 16 each: unsigned non-negative ReLU outputs, one per channel.
REQ-009 SHALL have port pool_vsync, output, 1: relu_vsync delayed one cycle.
REQ-010 SHALL have port pool_href, output, 1: one-cycle pulse per pooled pixel.
REQ-011 SHALL have ports pool_h_cnt and pool_v_cnt, output, 7 each: pooled column and row.
REQ-012 SHALL have ports pool_data1..pool_data16, output, 16 each: 2x2 maxima.

Function
REQ-013 SHALL accept a pixel only in cycles with relu_href=1, relu_h_cnt<2*(IN_W/2) and relu_v_cnt<2*(IN_H/2); all other pixels are ignored, so an odd trailing column or row is dropped.
REQ-014 SHALL, per channel, register the accepted pixel at even h_cnt as the pair left value.
REQ-015 SHALL, per channel at odd h_cnt, form hmax = unsigned max(left, current), 16-bit, with no width growth.
REQ-016 SHALL, on an even row, write hmax into a line buffer of IN_W/2 entries x 16 channels x 16 bits at index h_cnt>>1; pool_href stays 0.
REQ-017 SHALL, on an odd row, produce max(linebuf[h_cnt>>1], hmax) per channel.
REQ-018 SHALL register outputs with latency 1: the odd/odd input pixel at cycle N gives pool_href=1 at N+1, with pool_h_cnt=h_cnt>>1 and pool_v_cnt=v_cnt>>1.
REQ-019 SHALL hold pool_data*, pool_h_cnt and pool_v_cnt at their last values while pool_href=0.
REQ-020 SHALL, on a relu_vsync rising edge, clear the left registers and ignore stale line-buffer contents; the first even row of each frame fully overwrites the buffer before any odd-row read.
REQ-021 SHALL handle gaps in relu_href inside a line (stalls): pairing is by h_cnt parity, not cycle adjacency.
REQ-022 SHALL use the odd-row read/even-row write address rule only; the same index is never read and written in one cycle.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, drive pool_vsync=0, pool_href=0, pool_h_cnt=0, pool_v_cnt=0 and all pool_data*=0, and clear the left registers.
REQ-024 SHALL, on a reset asserted mid-frame, discard all partial work; output resumes after the next relu_vsync rising edge and a complete even/odd row pair.
REQ-025 SHALL NOT reset the line-buffer contents; they may map to RAM.

Configuration
REQ-026 SHALL, with macro LAYER1_MAXPOOL_ERR_EN defined, add port pool_err, output, 1: sticky flag set one cycle after any accepted pixel whose h_cnt is not the previous accepted h_cnt+1 within a line, or whose first pixel of a line has h_cnt!=0.
REQ-027 SHALL clear pool_err on rst or on a relu_vsync rising edge.
REQ-028 SHALL, without LAYER1_MAXPOOL_ERR_EN, have no pool_err port and no check logic; datapath behaviour is identical with and without the macro.

Structure
REQ-029 SHALL place DATA_W=16, CH_NUM=16, CNT_W=7 and the IN_W/IN_H defaults in shared package layer1_pool_pkg.
REQ-030 SHALL implement one channel (left register, line-buffer slice, comparators, output register) as sub-module pool_lane, instantiated CH_NUM times; parity, counter, href and vsync control stays in layer1_maxpool.

Verification
REQ-031 Single 2x2: frame IN_W=IN_H=24; row0 col0/1 on ch1 = 5, 9; row1 col0/1 = 3, 7 -> pool_href pulse at cnt (0,0), pool_data1=9, one cycle after row1 col1.
REQ-032 Full frame: ramp data = v*24+h on all channels -> 144 pool_href pulses, each value = (2v+1)*24+2h+1, counters raster 0..11.
REQ-033 Stall: relu_href dropped 3 cycles between col 4 and col 5 of an odd row -> same result as with no gap; no extra pool_href.
REQ-034 Reset mid-frame: rst=1 for 1 cycle at row 7 -> all outputs 0 next cycle; no pool_href until the next frame's row 1.
REQ-035 Odd size: IN_W=IN_H=25 -> col 24 and row 24 are ignored; exactly 144 outputs.
REQ-036 With LAYER1_MAXPOOL_ERR_EN defined: skip h_cnt 6 in row 2 -> pool_err=1 and held until the next vsync rising edge; a clean frame leaves pool_err=0.
